axicb_mst_buff: RTL and testbench

Synchronous buffering stage between an external AXI master and the crossbar switching logic. It implements the non-CDC buffered path of the master interface. Each of the five AXI channels gets its own first-word-fall-through FIFO. Outstanding write and read requests are counted so the master cannot issue more than `MST_OSTDREQ_NUM` address requests per direction. Channels arrive and leave already packed, so the block is agnostic to AXI4-lite, restricted or full signaling.

---
 rtl/axicb_pkg.sv | 25 ++
 rtl/axicb_scfifo.sv | 75 +++++++
 rtl/axicb_mst_buff.sv | 166 ++++++++++++++++
 tb/tb_axicb_mst_buff.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// -----------------------------------------------------------------------------
// axicb_pkg
// Shared helpers for the crossbar master buffering path.
//   axicb_pow2_depth(n) : FIFO depth rounded up to a power of two, minimum 2
//   axicb_cnt_w(n)      : bit width of a counter able to hold 0..n
// Related build option: AXICB_MST_OSTD_LIMIT_EN (consumed by axicb_mst_buff).
// -----------------------------------------------------------------------------
package axicb_pkg;

    function automatic int unsigned axicb_pow2_depth(input int unsigned n);
        int unsigned d;
        d = 2;
        for (int unsigned i = 0; i < 32; i++) begin
            if (d < n) begin
                d = d << 1;
            end
        end
        return d;
    endfunction

    function automatic int unsigned axicb_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// -----------------------------------------------------------------------------
// axicb_scfifo
// Single-clock first-word-fall-through FIFO.
// Parameters: DSIZE (entry width), DEPTH (power of two, >= 2).
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   push/wdata/full  : write side, push ignored while full
//   pop/rdata/empty  : read side, rdata valid whenever empty is low
// full and empty both read high while any reset is applied, so the
// surrounding handshakes show ready=0 and valid=0 during reset.
// -----------------------------------------------------------------------------
module axicb_scfifo
    import axicb_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4
)(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             push,
    input  logic [DSIZE-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [DSIZE-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [DSIZE-1:0] r_mem [DEPTH];

    logic w_in_rst;
    logic w_push;
    logic w_pop;

    assign w_in_rst = ~aresetn | srst;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign full  = w_in_rst |
                   ((r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]));
    assign empty = w_in_rst | (r_wr_ptr == r_rd_ptr);

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axicb_mst_buff.sv
// -----------------------------------------------------------------------------
// axicb_mst_buff
// Buffering stage between an external AXI master (i_*) and the crossbar
// switch (o_*). Each of the five packed channels passes through its own FWFT
// FIFO; W and R carry {last, ch}.
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   i_aw*/i_w*/i_ar* in, i_b*/i_r* out : master side
//   o_aw*/o_w*/o_ar* out, o_b*/o_r* in : switch side
// Build option AXICB_MST_OSTD_LIMIT_EN: when defined, write/read outstanding
// counters cap address acceptance at MST_OSTDREQ_NUM per direction; when
// undefined the counters do not exist and address readies follow FIFO full.
// -----------------------------------------------------------------------------
module axicb_mst_buff
    import axicb_pkg::*;
#(
    parameter int AWCH_W           = 8,
    parameter int WCH_W            = 8,
    parameter int BCH_W            = 8,
    parameter int ARCH_W           = 8,
    parameter int RCH_W            = 8,
    parameter int MST_OSTDREQ_NUM  = 4,
    parameter int MST_OSTDREQ_SIZE = 1
)(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              i_awvalid,
    output logic              i_awready,
    input  logic [AWCH_W-1:0] i_awch,
    input  logic              i_wvalid,
    output logic              i_wready,
    input  logic              i_wlast,
    input  logic [WCH_W-1:0]  i_wch,
    output logic              i_bvalid,
    input  logic              i_bready,
    output logic [BCH_W-1:0]  i_bch,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [ARCH_W-1:0] i_arch,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic              i_rlast,
    output logic [RCH_W-1:0]  i_rch,
    output logic              o_awvalid,
    input  logic              o_awready,
    output logic [AWCH_W-1:0] o_awch,
    output logic              o_wvalid,
    input  logic              o_wready,
    output logic              o_wlast,
    output logic [WCH_W-1:0]  o_wch,
    input  logic              o_bvalid,
    output logic              o_bready,
    input  logic [BCH_W-1:0]  o_bch,
    output logic              o_arvalid,
    input  logic              o_arready,
    output logic [ARCH_W-1:0] o_arch,
    input  logic              o_rvalid,
    output logic              o_rready,
    input  logic              o_rlast,
    input  logic [RCH_W-1:0]  o_rch
);

    localparam int REQ_DEPTH  = int'(axicb_pow2_depth(MST_OSTDREQ_NUM));
    localparam int DATA_DEPTH = int'(axicb_pow2_depth(MST_OSTDREQ_NUM * MST_OSTDREQ_SIZE));

    logic w_aw_full, w_aw_empty;
    logic w_w_full,  w_w_empty;
    logic w_b_full,  w_b_empty;
    logic w_ar_full, w_ar_empty;
    logic w_r_full,  w_r_empty;

    logic [WCH_W:0] w_w_rdata;
    logic [RCH_W:0] w_r_rdata;

    assign i_wready  = ~w_w_full;
    assign o_bready  = ~w_b_full;
    assign o_rready  = ~w_r_full;

    assign o_awvalid = ~w_aw_empty;
    assign o_wvalid  = ~w_w_empty;
    assign i_bvalid  = ~w_b_empty;
    assign o_arvalid = ~w_ar_empty;
    assign i_rvalid  = ~w_r_empty;

    assign {o_wlast, o_wch} = w_w_rdata;
    assign {i_rlast, i_rch} = w_r_rdata;

`ifdef AXICB_MST_OSTD_LIMIT_EN
    localparam int CNT_W = int'(axicb_cnt_w(MST_OSTDREQ_NUM));
    localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(MST_OSTDREQ_NUM);

    logic [CNT_W-1:0] r_wr_ostd;
    logic [CNT_W-1:0] r_rd_ostd;
    logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;

    assign i_awready = ~w_aw_full & (r_wr_ostd != OSTD_MAX);
    assign i_arready = ~w_ar_full & (r_rd_ostd != OSTD_MAX);

    assign w_wr_inc = i_awvalid & i_awready;
    assign w_wr_dec = i_bvalid & i_bready;
    assign w_rd_inc = i_arvalid & i_arready;
    assign w_rd_dec = i_rvalid & i_rready & i_rlast;

    // Decrement at zero is a protocol error: hold at zero instead of wrapping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ostd <= '0;
            r_rd_ostd <= '0;
        end else if (srst) begin
            r_wr_ostd <= '0;
            r_rd_ostd <= '0;
        end else begin
            if (w_wr_inc && !w_wr_dec) begin
                r_wr_ostd <= r_wr_ostd + CNT_W'(1);
            end else if (!w_wr_inc && w_wr_dec && (r_wr_ostd != '0)) begin
                r_wr_ostd <= r_wr_ostd - CNT_W'(1);
            end
            if (w_rd_inc && !w_rd_dec) begin
                r_rd_ostd <= r_rd_ostd + CNT_W'(1);
            end else if (!w_rd_inc && w_rd_dec && (r_rd_ostd != '0)) begin
                r_rd_ostd <= r_rd_ostd - CNT_W'(1);
            end
        end
    end

    a_wr_ostd_underflow: assert property (@(posedge aclk) disable iff (!aresetn || srst)
        !(w_wr_dec && (r_wr_ostd == '0)));
    a_rd_ostd_underflow: assert property (@(posedge aclk) disable iff (!aresetn || srst)
        !(w_rd_dec && (r_rd_ostd == '0)));
`else
    assign i_awready = ~w_aw_full;
    assign i_arready = ~w_ar_full;
`endif

    axicb_scfifo #(.DSIZE(AWCH_W), .DEPTH(REQ_DEPTH)) u_aw_fifo (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .push(i_awvalid & i_awready), .wdata(i_awch), .full(w_aw_full),
        .pop(o_awready), .rdata(o_awch), .empty(w_aw_empty)
    );

    axicb_scfifo #(.DSIZE(WCH_W + 1), .DEPTH(DATA_DEPTH)) u_w_fifo (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .push(i_wvalid & i_wready), .wdata({i_wlast, i_wch}), .full(w_w_full),
        .pop(o_wready), .rdata(w_w_rdata), .empty(w_w_empty)
    );

    axicb_scfifo #(.DSIZE(BCH_W), .DEPTH(REQ_DEPTH)) u_b_fifo (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .push(o_bvalid & o_bready), .wdata(o_bch), .full(w_b_full),
        .pop(i_bready), .rdata(i_bch), .empty(w_b_empty)
    );

    axicb_scfifo #(.DSIZE(ARCH_W), .DEPTH(REQ_DEPTH)) u_ar_fifo (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .push(i_arvalid & i_arready), .wdata(i_arch), .full(w_ar_full),
        .pop(o_arready), .rdata(o_arch), .empty(w_ar_empty)
    );

    axicb_scfifo #(.DSIZE(RCH_W + 1), .DEPTH(DATA_DEPTH)) u_r_fifo (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .push(o_rvalid & o_rready), .wdata({o_rlast, o_rch}), .full(w_r_full),
        .pop(i_rready), .rdata(w_r_rdata), .empty(w_r_empty)
    );

endmodule

// File: tb/tb_axicb_mst_buff.sv
// -----------------------------------------------------------------------------
// tb_axicb_mst_buff
// Directed bench for axicb_mst_buff with default parameters (8-bit channels,
// MST_OSTDREQ_NUM=4, MST_OSTDREQ_SIZE=1). Inputs change 1 ns after rising
// edges; outputs are sampled at that same point.
// Outstanding-limit checks are compiled only with AXICB_MST_OSTD_LIMIT_EN.
// -----------------------------------------------------------------------------
module tb_axicb_mst_buff;

    logic       aclk;
    logic       aresetn;
    logic       srst;
    logic       i_awvalid, i_awready;
    logic [7:0] i_awch;
    logic       i_wvalid, i_wready, i_wlast;
    logic [7:0] i_wch;
    logic       i_bvalid, i_bready;
    logic [7:0] i_bch;
    logic       i_arvalid, i_arready;
    logic [7:0] i_arch;
    logic       i_rvalid, i_rready, i_rlast;
    logic [7:0] i_rch;
    logic       o_awvalid, o_awready;
    logic [7:0] o_awch;
    logic       o_wvalid, o_wready, o_wlast;
    logic [7:0] o_wch;
    logic       o_bvalid, o_bready;
    logic [7:0] o_bch;
    logic       o_arvalid, o_arready;
    logic [7:0] o_arch;
    logic       o_rvalid, o_rready, o_rlast;
    logic [7:0] o_rch;

    int n_tests = 0;
    int n_fail  = 0;

    axicb_mst_buff #(
        .AWCH_W(8), .WCH_W(8), .BCH_W(8), .ARCH_W(8), .RCH_W(8),
        .MST_OSTDREQ_NUM(4), .MST_OSTDREQ_SIZE(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_readies(input string tag, input logic [31:0] exp);
        chk({tag, "_i_awready"}, 32'(i_awready), exp);
        chk({tag, "_i_wready"},  32'(i_wready),  exp);
        chk({tag, "_i_arready"}, 32'(i_arready), exp);
        chk({tag, "_o_bready"},  32'(o_bready),  exp);
        chk({tag, "_o_rready"},  32'(o_rready),  exp);
    endtask

    initial begin
        int e;
        int d;
        logic pushed;
        logic popped;

        aresetn = 1'b0; srst = 1'b0;
        i_awvalid = 1'b0; i_awch = '0;
        i_wvalid = 1'b0; i_wlast = 1'b0; i_wch = '0;
        i_bready = 1'b0; i_arvalid = 1'b0; i_arch = '0; i_rready = 1'b0;
        o_awready = 1'b0; o_wready = 1'b0; o_bvalid = 1'b0; o_bch = '0;
        o_arready = 1'b0; o_rvalid = 1'b0; o_rlast = 1'b0; o_rch = '0;

        // Reset state
        #3;
        chk_readies("rst", 0);
        chk("rst_i_bvalid", 32'(i_bvalid), 0);
        chk("rst_i_rvalid", 32'(i_rvalid), 0);
        chk("rst_o_awvalid", 32'(o_awvalid), 0);
        chk("rst_o_wvalid", 32'(o_wvalid), 0);
        chk("rst_o_arvalid", 32'(o_arvalid), 0);
        step();
        aresetn = 1'b1;
        #1;
        chk_readies("post_rst", 1);

        // Single AW, one cycle latency
        step();
        i_awvalid = 1'b1; i_awch = 8'hA5;
        chk("aw1_ready", 32'(i_awready), 1);
        step();
        i_awvalid = 1'b0;
        chk("aw1_o_awvalid", 32'(o_awvalid), 1);
        chk("aw1_o_awch", 32'(o_awch), 32'hA5);
`ifdef AXICB_MST_OSTD_LIMIT_EN
        chk("aw1_wr_ostd", 32'(dut.r_wr_ostd), 1);
`endif
        o_awready = 1'b1;
        step();
        chk("aw1_drained", 32'(o_awvalid), 0);

        // Synchronous reset clears state and forces readies low
        srst = 1'b1;
        #1;
        chk("srst_i_awready", 32'(i_awready), 0);
        step();
        srst = 1'b0;
        #1;
        chk("srst_rel_i_awready", 32'(i_awready), 1);
`ifdef AXICB_MST_OSTD_LIMIT_EN
        chk("srst_wr_ostd", 32'(dut.r_wr_ostd), 0);

        // Outstanding limit: 4 accepted, 5th held until a B returns
        for (int k = 0; k < 4; k++) begin
            i_awvalid = 1'b1; i_awch = 8'(k);
            chk("lim_aw_ready", 32'(i_awready), 1);
            step();
            chk("lim_o_awch", 32'(o_awch), 32'(k));
        end
        i_awch = 8'h04;
        chk("lim_aw_blocked", 32'(i_awready), 0);
        chk("lim_wr_ostd4", 32'(dut.r_wr_ostd), 4);
        step();
        chk("lim_aw_still_blocked", 32'(i_awready), 0);
        chk("lim_o_awvalid_idle", 32'(o_awvalid), 0);
        o_bvalid = 1'b1; o_bch = 8'h3C; i_bready = 1'b1;
        step();
        o_bvalid = 1'b0;
        chk("lim_i_bvalid", 32'(i_bvalid), 1);
        chk("lim_i_bch", 32'(i_bch), 32'h3C);
        chk("lim_aw_blocked_b", 32'(i_awready), 0);
        step();
        i_bready = 1'b0;
        chk("lim_wr_ostd3", 32'(dut.r_wr_ostd), 3);
        chk("lim_aw_reopen", 32'(i_awready), 1);
        step();
        i_awvalid = 1'b0;
        chk("lim_aw5_valid", 32'(o_awvalid), 1);
        chk("lim_aw5_ch", 32'(o_awch), 32'h04);
        chk("lim_wr_ostd4b", 32'(dut.r_wr_ostd), 4);
        step();
`else
        // No limit: 6 AW accepted back-to-back while the switch drains
        for (int k = 0; k < 6; k++) begin
            i_awvalid = 1'b1; i_awch = 8'(k);
            chk("nolim_aw_ready", 32'(i_awready), 1);
            step();
            chk("nolim_o_awvalid", 32'(o_awvalid), 1);
            chk("nolim_o_awch", 32'(o_awch), 32'(k));
        end
        i_awvalid = 1'b0;
        step();
        chk("nolim_drained", 32'(o_awvalid), 0);
`endif

        // W burst of 8 into depth-4 FIFO with switch stalled
        o_wready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_wvalid = 1'b1; i_wch = 8'(k); i_wlast = 1'b0;
            chk("w_fill_ready", 32'(i_wready), 1);
            step();
        end
        i_wch = 8'h04;
        chk("w_full_ready", 32'(i_wready), 0);
        step();
        chk("w_full_ready_hold", 32'(i_wready), 0);
        chk("w_head", 32'(o_wch), 0);
        e = 0;
        d = 4;
        o_wready = 1'b1;
        for (int c = 0; c < 40 && e < 8; c++) begin
            pushed = i_wvalid & i_wready;
            popped = o_wvalid;
            if (popped) begin
                chk("w_data", 32'(o_wch), 32'(e));
                chk("w_last", 32'(o_wlast), (e == 7) ? 1 : 0);
            end
            step();
            if (popped) e++;
            if (pushed) begin
                d++;
                if (d < 8) begin
                    i_wch = 8'(d); i_wlast = (d == 7);
                end else begin
                    i_wvalid = 1'b0; i_wlast = 1'b0;
                end
            end
        end
        chk("w_beats_out", 32'(e), 8);
        chk("w_empty_after", 32'(o_wvalid), 0);
        o_wready = 1'b0;

        // AR buffering, R data, simultaneous AR and R-last
        i_arvalid = 1'b1; i_arch = 8'h51;
        step();
        i_arch = 8'h52;
        step();
        i_arvalid = 1'b0;
        chk("ar_o_arvalid", 32'(o_arvalid), 1);
        chk("ar_o_arch", 32'(o_arch), 32'h51);
`ifdef AXICB_MST_OSTD_LIMIT_EN
        chk("ar_rd_ostd2", 32'(dut.r_rd_ostd), 2);
`endif
        o_rvalid = 1'b1; o_rch = 8'h11; o_rlast = 1'b1;
        chk("r_o_rready", 32'(o_rready), 1);
        step();
        o_rvalid = 1'b0; o_rlast = 1'b0;
        chk("r_i_rvalid", 32'(i_rvalid), 1);
        chk("r_i_rch", 32'(i_rch), 32'h11);
        chk("r_i_rlast", 32'(i_rlast), 1);
        i_arvalid = 1'b1; i_arch = 8'h53; i_rready = 1'b1;
        chk("ar_r_same_arready", 32'(i_arready), 1);
        step();
        i_arvalid = 1'b0; i_rready = 1'b0;
        chk("r_popped", 32'(i_rvalid), 0);
`ifdef AXICB_MST_OSTD_LIMIT_EN
        chk("ar_r_same_rd_ostd", 32'(dut.r_rd_ostd), 2);
`endif

        // Async reset with 3 R beats buffered
        o_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            o_rch = 8'(8'h20 + k); o_rlast = (k == 2);
            step();
        end
        o_rvalid = 1'b0; o_rlast = 1'b0;
        chk("rb_i_rvalid", 32'(i_rvalid), 1);
        chk("rb_i_rch", 32'(i_rch), 32'h20);
        chk("rb_i_rlast", 32'(i_rlast), 0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_i_rvalid", 32'(i_rvalid), 0);
        chk_readies("arst", 0);
        step();
        chk_readies("arst_hold", 0);
        aresetn = 1'b1;
        step();
        chk("arst_rel_i_rvalid", 32'(i_rvalid), 0);
        chk("arst_rel_o_arvalid", 32'(o_arvalid), 0);
        chk("arst_rel_o_awvalid", 32'(o_awvalid), 0);
        chk_readies("arst_rel", 1);
`ifdef AXICB_MST_OSTD_LIMIT_EN
        chk("arst_wr_ostd", 32'(dut.r_wr_ostd), 0);
        chk("arst_rd_ostd", 32'(dut.r_rd_ostd), 0);
`endif

        // Synchronous reset with an AW buffered
        o_awready = 1'b0;
        i_awvalid = 1'b1; i_awch = 8'h77;
        step();
        i_awvalid = 1'b0;
        chk("srst2_pre_valid", 32'(o_awvalid), 1);
        srst = 1'b1;
        #1;
        chk("srst2_valid_forced", 32'(o_awvalid), 0);
        step();
        srst = 1'b0;
        #1;
        chk("srst2_after_valid", 32'(o_awvalid), 0);
        chk("srst2_after_ready", 32'(i_awready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
